phys_reg_free_list: RTL and testbench

PHYS_REG_FREE_LIST -- requirements
Module: phys_reg_free_list

---
 rtl/phys_reg_free_list.sv | 102 ++++++++++
 tb/tb_phys_reg_free_list.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phys_reg_free_list.sv
// Physical register free list: circular buffer of free tags with up to four
// allocations (dispatch) and four releases (commit) per cycle.
module phys_reg_free_list #(
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned INDEX    = 6,
    parameter int unsigned WIDTH    = 7,
    parameter int unsigned RMT_SIZE = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alloc_req_i,
    input  logic [2:0]           alloc_cnt_i,
    output logic                 alloc_grant_o,
    output logic [4*WIDTH-1:0]   alloc_tag_o,
    input  logic [3:0]           free_valid_i,
    input  logic [4*WIDTH-1:0]   free_tag_i,
    output logic [INDEX:0]       free_count_o,
    output logic                 stall_o,
    output logic                 overflow_o
);

    localparam int unsigned LANES = 4;
    localparam int unsigned CNTW  = INDEX + 1;
    localparam int unsigned CAPW  = INDEX + 2;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [INDEX-1:0] head;
    logic [INDEX-1:0] tail;
    logic [CNTW-1:0]  count;
    logic             overflow;

    logic [2:0]       cnt_eff;
    logic [2:0]       alloc_n;
    logic [CAPW-1:0]  cap;
    logic [2:0]       acc;
    logic             drop;
    logic [LANES-1:0] wr_en;
    logic [INDEX-1:0] wr_idx [LANES];
    logic [CNTW-1:0]  count_next;

    // Grant decision uses the registered count only.
    always_comb begin
        cnt_eff       = (alloc_cnt_i > 3'd4) ? 3'd4 : alloc_cnt_i;
        alloc_grant_o = alloc_req_i && (count >= CNTW'(cnt_eff));
        stall_o       = alloc_req_i && !alloc_grant_o;
        alloc_n       = alloc_grant_o ? cnt_eff : 3'd0;
    end

    always_comb begin
        alloc_tag_o = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (3'(k) < cnt_eff)
                alloc_tag_o[k*WIDTH +: WIDTH] = mem[head + INDEX'(k)];
        end
    end

    // Compact valid release lanes into consecutive slots; slots freed by a
    // same-cycle grant count toward capacity, excess high lanes are dropped.
    always_comb begin
        cap  = CAPW'(DEPTH) - CAPW'(count) + CAPW'(alloc_n);
        acc  = 3'd0;
        drop = 1'b0;
        wr_en = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            wr_idx[k] = tail + INDEX'(acc);
            if (free_valid_i[k]) begin
                if (CAPW'(acc) < cap) begin
                    wr_en[k] = 1'b1;
                    acc      = acc + 3'd1;
                end else begin
                    drop = 1'b1;
                end
            end
        end
        count_next = count - CNTW'(alloc_n) + CNTW'(acc);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[INDEX'(i)] <= WIDTH'(i + RMT_SIZE);
            head     <= '0;
            tail     <= '0;
            count    <= CNTW'(DEPTH);
            overflow <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < LANES; k++) begin
                if (wr_en[k])
                    mem[wr_idx[k]] <= free_tag_i[k*WIDTH +: WIDTH];
            end
            head  <= head + INDEX'(alloc_n);
            tail  <= tail + INDEX'(acc);
            count <= count_next;
            if (drop)
                overflow <= 1'b1;
        end
    end

    assign free_count_o = count;
    assign overflow_o   = overflow;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Bench for phys_reg_free_list: directed scenarios plus randomized traffic
// checked against a queue-based model of the free list.
module tb_phys_reg_free_list;

    localparam int DEPTH = 64;
    localparam int WIDTH = 7;

    logic              clk = 1'b0;
    logic              reset;
    logic              alloc_req;
    logic [2:0]        alloc_cnt;
    logic              alloc_grant;
    logic [4*WIDTH-1:0] alloc_tag;
    logic [3:0]        free_valid;
    logic [4*WIDTH-1:0] free_tag;
    logic [6:0]        free_count;
    logic              stall;
    logic              overflow;

    int passes = 0;
    int checks = 0;

    int q[$];
    bit m_ovf;

    phys_reg_free_list #(.DEPTH(64), .INDEX(6), .WIDTH(7), .RMT_SIZE(64)) dut (
        .clk(clk), .reset(reset),
        .alloc_req_i(alloc_req), .alloc_cnt_i(alloc_cnt),
        .alloc_grant_o(alloc_grant), .alloc_tag_o(alloc_tag),
        .free_valid_i(free_valid), .free_tag_i(free_tag),
        .free_count_o(free_count), .stall_o(stall), .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    task automatic m_reset();
        q.delete();
        for (int i = 0; i < DEPTH; i++) q.push_back(64 + i);
        m_ovf = 1'b0;
    endtask

    function automatic int eff(input int c);
        return (c > 4) ? 4 : c;
    endfunction

    function automatic bit m_grant(input bit req, input int c);
        return req && (q.size() >= eff(c));
    endfunction

    // Expected lane value; -1 when the lane reads a slot holding no free tag.
    function automatic int m_lane(input int k, input int c);
        if (k >= eff(c)) return 0;
        if (k < q.size()) return q[k];
        return -1;
    endfunction

    task automatic m_apply(input bit req, input int c, input logic [3:0] v,
                           input logic [4*WIDTH-1:0] t);
        int n;
        int room;
        n = m_grant(req, c) ? eff(c) : 0;
        repeat (n) void'(q.pop_front());
        room = DEPTH - q.size();
        for (int k = 0; k < 4; k++) begin
            if (v[k]) begin
                if (room > 0) begin
                    q.push_back(int'(t[k*WIDTH +: WIDTH]));
                    room--;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic drive(input bit req, input int c, input logic [3:0] v,
                         input logic [4*WIDTH-1:0] t);
        alloc_req  = req;
        alloc_cnt  = 3'(c);
        free_valid = v;
        free_tag   = t;
    endtask

    task automatic do_reset();
        drive(0, 0, 4'b0, '0);
        reset = 1'b1;
        m_reset();
        #2;
        reset = 1'b0;
    endtask

    // Step one clock with the currently driven inputs, updating the model.
    task automatic step();
        m_apply(alloc_req, int'(alloc_cnt), free_valid, free_tag);
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1;
        checks++; if (free_count !== 7'd64) $display("FAIL reset_count got %0d exp 64", free_count); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %0b exp 0", overflow); else passes++;
        drive(1, 5, 4'b1111, {7'd1, 7'd2, 7'd3, 7'd4});
        #1;
        checks++; if (alloc_grant !== 1'b1 || stall !== 1'b0)
            $display("FAIL reset_grant got grant=%0b stall=%0b exp grant=1 stall=0", alloc_grant, stall); else passes++;
        @(posedge clk); #1;
        checks++; if (free_count !== 7'd64) $display("FAIL reset_discard got %0d exp 64", free_count); else passes++;
        reset = 1'b0;
        m_reset();
        drive(0, 0, 4'b0, '0);
    endtask

    task automatic test_alloc_basic();
        drive(1, 4, 4'b0, '0);
        #1;
        checks++; if (alloc_grant !== 1'b1) $display("FAIL basic_grant got %0b exp 1", alloc_grant); else passes++;
        checks++; if (alloc_tag !== {7'd67, 7'd66, 7'd65, 7'd64})
            $display("FAIL basic_tags got %h exp %h", alloc_tag, {7'd67, 7'd66, 7'd65, 7'd64}); else passes++;
        step();
        checks++; if (free_count !== 7'd60) $display("FAIL basic_count got %0d exp 60", free_count); else passes++;
    endtask

    task automatic test_drain();
        for (int i = 0; i < 15; i++) begin
            drive(1, 4, 4'b0, '0);
            #1;
            for (int k = 0; k < 4; k++) begin
                checks++; if (int'(alloc_tag[k*WIDTH +: WIDTH]) !== m_lane(k, 4))
                    $display("FAIL drain_tag cyc %0d lane %0d got %0d exp %0d", i, k, alloc_tag[k*WIDTH +: WIDTH], m_lane(k, 4)); else passes++;
            end
            step();
        end
        checks++; if (free_count !== 7'd0) $display("FAIL drain_empty got %0d exp 0", free_count); else passes++;
        drive(1, 1, 4'b0, '0);
        #1;
        checks++; if (stall !== 1'b1 || alloc_grant !== 1'b0)
            $display("FAIL empty_stall got stall=%0b grant=%0b exp stall=1 grant=0", stall, alloc_grant); else passes++;
        step();
        checks++; if (free_count !== 7'd0) $display("FAIL empty_hold got %0d exp 0", free_count); else passes++;
    endtask

    task automatic test_release_compact();
        drive(0, 0, 4'b1010, {7'd9, 7'd0, 7'd5, 7'd0});
        step();
        checks++; if (free_count !== 7'd2) $display("FAIL compact_count got %0d exp 2", free_count); else passes++;
        drive(1, 2, 4'b0, '0);
        #1;
        checks++; if (alloc_grant !== 1'b1) $display("FAIL compact_grant got %0b exp 1", alloc_grant); else passes++;
        checks++; if (alloc_tag !== {7'd0, 7'd0, 7'd9, 7'd5})
            $display("FAIL compact_tags got %h exp %h", alloc_tag, {7'd0, 7'd0, 7'd9, 7'd5}); else passes++;
        step();
        checks++; if (free_count !== 7'd0) $display("FAIL compact_after got %0d exp 0", free_count); else passes++;
    endtask

    task automatic test_same_cycle_empty();
        drive(1, 1, 4'b0001, {21'd0, 7'd33});
        #1;
        checks++; if (stall !== 1'b1 || alloc_grant !== 1'b0)
            $display("FAIL same_stall got stall=%0b grant=%0b exp stall=1 grant=0", stall, alloc_grant); else passes++;
        step();
        checks++; if (free_count !== 7'd1) $display("FAIL same_count got %0d exp 1", free_count); else passes++;
        drive(1, 1, 4'b0, '0);
        #1;
        checks++; if (alloc_tag !== {21'd0, 7'd33}) $display("FAIL same_tag got %h exp %h", alloc_tag, {21'd0, 7'd33}); else passes++;
        step();
    endtask

    task automatic test_overflow_wrap();
        do_reset();
        drive(1, 2, 4'b1111, {7'd13, 7'd12, 7'd11, 7'd10});
        #1;
        checks++; if (alloc_grant !== 1'b1) $display("FAIL ovf_grant got %0b exp 1", alloc_grant); else passes++;
        step();
        checks++; if (free_count !== 7'd64) $display("FAIL ovf_count got %0d exp 64", free_count); else passes++;
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_set got %0b exp 1", overflow); else passes++;
        drive(0, 0, 4'b0, '0);
        repeat (3) step();
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %0b exp 1", overflow); else passes++;
        // Drain across the head wrap; the last two tags are the accepted releases.
        for (int i = 0; i < 16; i++) begin
            drive(1, 4, 4'b0, '0);
            #1;
            for (int k = 0; k < 4; k++) begin
                checks++; if (int'(alloc_tag[k*WIDTH +: WIDTH]) !== m_lane(k, 4))
                    $display("FAIL wrap_tag cyc %0d lane %0d got %0d exp %0d", i, k, alloc_tag[k*WIDTH +: WIDTH], m_lane(k, 4)); else passes++;
            end
            step();
        end
        checks++; if (free_count !== 7'd0) $display("FAIL wrap_empty got %0d exp 0", free_count); else passes++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(0, 0, 4'b0001, {21'd0, 7'd1});
        step();
        checks++; if (overflow !== 1'b1) $display("FAIL mid_pre_ovf got %0b exp 1", overflow); else passes++;
        for (int i = 0; i < 11; i++) begin drive(1, 4, 4'b0, '0); step(); end
        drive(1, 3, 4'b0, '0);
        step();
        checks++; if (free_count !== 7'd17) $display("FAIL mid_count17 got %0d exp 17", free_count); else passes++;
        drive(1, 4, 4'b1111, {7'd3, 7'd2, 7'd1, 7'd0});
        #2;
        reset = 1'b1;
        m_reset();
        #1;
        checks++; if (free_count !== 7'd64) $display("FAIL mid_async got %0d exp 64", free_count); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL mid_ovf got %0b exp 0", overflow); else passes++;
        @(posedge clk); #1;
        reset = 1'b0;
        drive(1, 1, 4'b0, '0);
        #1;
        checks++; if (alloc_tag !== {21'd0, 7'd64}) $display("FAIL mid_tag got %h exp %h", alloc_tag, {21'd0, 7'd64}); else passes++;
        step();
        checks++; if (free_count !== 7'd63) $display("FAIL mid_after got %0d exp 63", free_count); else passes++;
    endtask

    task automatic test_random();
        logic [3:0] v;
        bit         req;
        int         c;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            req = 1'($urandom_range(0, 1));
            c   = $urandom_range(0, 7);
            v   = 4'($urandom);
            if (i < 200) v = v & 4'($urandom) & 4'($urandom);
            drive(req, c, v, 28'($urandom));
            #1;
            checks++; if (alloc_grant !== m_grant(req, c) || stall !== (req && !m_grant(req, c)))
                $display("FAIL rnd_grant cyc %0d got grant=%0b stall=%0b exp grant=%0b", i, alloc_grant, stall, m_grant(req, c)); else passes++;
            for (int k = 0; k < 4; k++) begin
                if (m_lane(k, c) >= 0) begin
                    checks++; if (int'(alloc_tag[k*WIDTH +: WIDTH]) !== m_lane(k, c))
                        $display("FAIL rnd_tag cyc %0d lane %0d got %0d exp %0d", i, k, alloc_tag[k*WIDTH +: WIDTH], m_lane(k, c)); else passes++;
                end
            end
            step();
            checks++; if (int'(free_count) !== q.size())
                $display("FAIL rnd_count cyc %0d got %0d exp %0d", i, free_count, q.size()); else passes++;
            checks++; if (overflow !== m_ovf)
                $display("FAIL rnd_ovf cyc %0d got %0b exp %0b", i, overflow, m_ovf); else passes++;
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 4'b0, '0);
        m_reset();
        test_reset();
        test_alloc_basic();
        test_drain();
        test_release_compact();
        test_same_cycle_empty();
        test_overflow_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
